// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types for the TPU control-path counters
package tpu_pkg;

    typedef enum logic [1:0] {
        DCTR_IDLE    = 2'd0,
        DCTR_RUN     = 2'd1,
        DCTR_EXPIRED = 2'd2
    } dsp_down_ctr_state_t;

    localparam int DCTR_MIN_EVENT_LATENCY = 1;
    localparam int DCTR_MAX_EVENT_LATENCY = 4;

endpackage

// File: rtl/dsp_ctr_event_pipe.sv
// rtl/dsp_ctr_event_pipe.sv - fixed-depth 1-bit event delay line with synchronous clear
module dsp_ctr_event_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (clr) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/dsp_down_ctr.sv
// rtl/dsp_down_ctr.sv - loadable down-counter with one-shot/auto-reload and delayed terminal-count event
module dsp_down_ctr
    import tpu_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int EVENT_LATENCY = 2,
    parameter bit AUTO_RELOAD   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] start_val,
    input  logic                     abort,
    output logic [COUNTER_WIDTH-1:0] ctr_val,
    output logic                     ctr_event,
    output logic                     busy,
    output logic                     done
);

    (* use_dsp = "yes" *) logic [COUNTER_WIDTH-1:0] ctr;
    logic [COUNTER_WIDTH-1:0] start_reg;
    dsp_down_ctr_state_t      state;
    logic                     tc;

    // tc is a pure function of state/enable/ctr; load/abort only override the next-state action
    assign tc = (state == DCTR_RUN) && enable && (ctr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr       <= '0;
            start_reg <= '0;
            state     <= DCTR_IDLE;
        end else if (load) begin
            ctr       <= start_val;
            start_reg <= start_val;
            state     <= DCTR_RUN;
        end else if (abort) begin
            state <= DCTR_IDLE;
        end else if (state == DCTR_RUN && enable) begin
            if (ctr == '0) begin
                if (AUTO_RELOAD) begin
                    ctr <= start_reg;
                end else begin
                    state <= DCTR_EXPIRED;
                end
            end else begin
                ctr <= ctr - COUNTER_WIDTH'(1);
            end
        end
    end

    dsp_ctr_event_pipe #(
        .DEPTH(EVENT_LATENCY)
    ) u_event_pipe (
        .clk (clk),
        .clr (rst),
        .din (tc),
        .dout(ctr_event)
    );

    assign ctr_val = ctr;
    assign busy    = (state == DCTR_RUN);
    assign done    = !AUTO_RELOAD && (state == DCTR_EXPIRED);

endmodule

// File: tb/tb_dsp_down_ctr.sv
// tb/tb_dsp_down_ctr.sv - directed bench for dsp_down_ctr (one-shot and auto-reload instances)
module tb_dsp_down_ctr;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         load;
    logic [W-1:0] start_val;
    logic         abort;

    logic [W-1:0] os_ctr_val, ar_ctr_val;
    logic         os_event, ar_event;
    logic         os_busy, ar_busy;
    logic         os_done, ar_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_down_ctr #(.COUNTER_WIDTH(W), .EVENT_LATENCY(2), .AUTO_RELOAD(1'b0)) u_oneshot (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .start_val(start_val), .abort(abort),
        .ctr_val(os_ctr_val), .ctr_event(os_event), .busy(os_busy), .done(os_done)
    );

    dsp_down_ctr #(.COUNTER_WIDTH(W), .EVENT_LATENCY(2), .AUTO_RELOAD(1'b1)) u_reload (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .start_val(start_val), .abort(abort),
        .ctr_val(ar_ctr_val), .ctr_event(ar_event), .busy(ar_busy), .done(ar_done)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; abort = 1'b0; enable = 1'b0; start_val = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_ctr1[7]  = '{3, 2, 1, 0, 0, 0, 0};
        int exp_ev1[7]   = '{0, 0, 0, 0, 0, 1, 0};
        int exp_busy1[7] = '{1, 1, 1, 1, 0, 0, 0};
        int exp_done1[7] = '{0, 0, 0, 0, 1, 1, 1};
        int en2[8]       = '{1, 0, 1, 0, 1, 0, 0, 0};
        int exp_ctr2[8]  = '{2, 1, 1, 0, 0, 0, 0, 0};
        int exp_ev2[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};

        // reset state
        do_reset();
        check("rst_ctr", os_ctr_val, 0);
        check("rst_busy", W'(os_busy), 0);
        check("rst_done", W'(os_done), 0);
        check("rst_event", W'(os_event), 0);

        // one-shot countdown from 3
        load = 1'b1; start_val = 3; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("os_ctr_c%0d", i + 1), os_ctr_val, W'(exp_ctr1[i]));
            check($sformatf("os_ev_c%0d", i + 1), W'(os_event), W'(exp_ev1[i]));
            check($sformatf("os_busy_c%0d", i + 1), W'(os_busy), W'(exp_busy1[i]));
            check($sformatf("os_done_c%0d", i + 1), W'(os_done), W'(exp_done1[i]));
            tick();
        end

        // enable gaps
        do_reset();
        load = 1'b1; start_val = 2; enable = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enable = en2[i][0];
            check($sformatf("gap_ctr_c%0d", i + 1), os_ctr_val, W'(exp_ctr2[i]));
            check($sformatf("gap_ev_c%0d", i + 1), W'(os_event), W'(exp_ev2[i]));
            tick();
        end
        check("gap_done", W'(os_done), 1);

        // auto-reload with N=1
        do_reset();
        load = 1'b1; start_val = 1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("ar_ctr_c%0d", i), ar_ctr_val, (i % 2 == 1) ? W'(1) : W'(0));
            check($sformatf("ar_ev_c%0d", i), W'(ar_event), (i % 2 == 0 && i >= 4) ? W'(1) : W'(0));
            check($sformatf("ar_done_c%0d", i), W'(ar_done), 0);
            check($sformatf("ar_busy_c%0d", i), W'(ar_busy), 1);
            tick();
        end

        // restart: load 5, reload 1 when ctr reaches 3
        do_reset();
        load = 1'b1; start_val = 5; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        check("rs_ctr_c3", os_ctr_val, 3);
        load = 1'b1; start_val = 1;
        tick();
        load = 1'b0;
        check("rs_ctr_c4", os_ctr_val, 1);
        tick();
        check("rs_ctr_c5", os_ctr_val, 0);
        check("rs_busy_c5", W'(os_busy), 1);
        tick();
        check("rs_done_c6", W'(os_done), 1);
        check("rs_ev_c6", W'(os_event), 0);
        tick();
        check("rs_ev_c7", W'(os_event), 1);

        // abort at ctr=2
        do_reset();
        load = 1'b1; start_val = 4; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        check("ab_ctr_c3", os_ctr_val, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 4; i <= 7; i++) begin
            check($sformatf("ab_busy_c%0d", i), W'(os_busy), 0);
            check($sformatf("ab_ctr_c%0d", i), os_ctr_val, 2);
            check($sformatf("ab_ev_c%0d", i), W'(os_event), 0);
            check($sformatf("ab_done_c%0d", i), W'(os_done), 0);
            tick();
        end

        // zero start value
        do_reset();
        load = 1'b1; start_val = 0; enable = 1'b1;
        tick();
        load = 1'b0;
        check("z_ctr_c1", os_ctr_val, 0);
        check("z_busy_c1", W'(os_busy), 1);
        tick();
        check("z_done_c2", W'(os_done), 1);
        check("z_ev_c2", W'(os_event), 0);
        tick();
        check("z_ev_c3", W'(os_event), 1);

        // rst and load together: reset wins
        rst = 1'b1; load = 1'b1; start_val = 7;
        tick();
        rst = 1'b0; load = 1'b0;
        check("rl_ctr", os_ctr_val, 0);
        check("rl_busy", W'(os_busy), 0);
        check("rl_done", W'(os_done), 0);
        check("rl_event", W'(os_event), 0);

        // rst one cycle after tc suppresses the pending event
        load = 1'b1; start_val = 0; enable = 1'b1;
        tick();
        load = 1'b0;
        check("sup_busy_c1", W'(os_busy), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sup_ev_c3", W'(os_event), 0);
        check("sup_done_c3", W'(os_done), 0);
        tick();
        check("sup_ev_c4", W'(os_event), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
